mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001: Parameter DEPTH, default 256; number of 64-bit doublewords stored.
REQ-002: Parameter LATENCY, default 2, legal 1..15; cycles from request acceptance to rsp_valid.
REQ-003: Parameter BASE_ADDR, default 64'h8000_0000; byte address of doubleword 0.
REQ-004: One clock, clk; reset is asynchronous and active-high, rst.
REQ-005: clk  input  1  rising-edge clock.
REQ-006: rst  input  1  asynchronous active-high reset.
REQ-007: req_valid  input  1  requester presents a request.
REQ-008: req_ready  output  1  responder accepts a request this cycle.
REQ-009: req_addr  input  64  byte address; bits [2:0] ignored.
REQ-010: req_wen  input  1  1 = store, 0 = load.
REQ-011: req_wdata  input  64  store data, byte-lane aligned.
REQ-012: req_wmask  input  8  store byte enables, bit i -> wdata[8i+7:8i].
REQ-013: rsp_valid  output  1  response held until accepted.
REQ-014: rsp_ready  input  1  requester accepts the response.
REQ-015: rsp_rdata  output  64  full doubleword for loads; 0 for stores and errors.
REQ-016: rsp_err  output  1  address outside [BASE_ADDR, BASE_ADDR+DEPTH*8).

Function
REQ-017: FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, combinational from state.
REQ-018: Accept on the edge where req_valid && req_ready; latch addr, wen, wdata, wmask and the range check.
REQ-019: On accept: LATENCY==1 -> RESP; otherwise -> WAIT with counter = LATENCY-2.
REQ-020: WAIT decrements the counter each cycle; at 0 -> RESP; rsp_valid therefore rises exactly LATENCY edges after acceptance.
REQ-021: Store commits to the array on the acceptance edge; only masked bytes change; wmask=0 changes nothing.
REQ-022: Load data is sampled on the edge entering RESP, so it reflects all earlier committed stores.
REQ-023: Out-of-range request: no array update, rsp_err=1, rsp_rdata=0.
REQ-024: RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on the handshake edge -> IDLE and rsp_valid=0.
REQ-025: One outstanding transaction; minimum request-to-request spacing is LATENCY+1 cycles with rsp_ready tied high.
REQ-026: req_valid during WAIT/RESP is ignored (not accepted, not lost from the requester's view since req_ready=0).
REQ-027: Index = (req_addr - BASE_ADDR) >> 3, truncated to clog2(DEPTH) bits after the range check passes.

Reset
REQ-028: rst asserted forces state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request fields 0.
REQ-029: Array contents are not reset; a store accepted before rst remains committed; a pending response is dropped.
REQ-030: First acceptance is possible on the first rising edge after rst deasserts.

Structure
REQ-031: Package mem_resp_pkg holds the state enum, ADDR_W=64, DATA_W=64, MASK_W=8 and the latency counter width.
REQ-032: Sub-module mem_resp_array: DEPTH x 64 storage, one byte-masked write port, one synchronous read port.
REQ-033: FSM, counter, range check and response registers live in mem_responder.

Verification
REQ-034: LATENCY=2; store addr 0x8000_0010, wdata 0x1122334455667788, mask 0xFF, then load same -> rsp_valid 2 edges after each accept, load rdata 0x1122334455667788, err 0.
REQ-035: Partial store mask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788 -> load returns 0x11223344_BBBBBBBB.
REQ-036: Load at 0x7FFF_FFF8 and at BASE_ADDR+DEPTH*8 -> rsp_err=1, rdata=0; following in-range load unaffected.
REQ-037: rsp_ready held low 5 cycles -> rsp_valid/rdata/err stable, req_ready=0 throughout; 1 cycle after handshake req_ready=1.
REQ-038: rst pulsed during WAIT of a load -> rsp_valid never asserts for it, outputs 0, req_ready=1 next edge; earlier store data still readable.
REQ-039: LATENCY=1 build, back-to-back loads with rsp_ready=1 -> one acceptance every 2 cycles, rsp_valid 1 edge after each accept.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_responder memory model.
// No logic; no latency; no backpressure.
package mem_resp_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x 64-bit storage with one byte-masked write port and one registered read port.
// Write and read both take effect on the clock edge; no backpressure.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately never reset so stores survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wr_mask[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_idx];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/WAIT/RESP FSM with range check.
// Response LATENCY edges after acceptance; req_ready low until the response handshakes.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int              DEPTH     = 256,
    parameter int              LATENCY   = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) << 3;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              wen_q;
    logic              err_q;

    logic [ADDR_W-1:0] off;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    assign off      = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && (off < SPAN);
    assign req_idx  = off[IDX_W+2:3];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_wen && in_range && !rst;

    // With LATENCY==1 the acceptance edge is also the edge entering RESP.
    assign rd_en  = (LATENCY == 1) ? (accept && !req_wen && in_range)
                                   : (state_q == WAIT && cnt_q == '0 && !wen_q && !err_q);
    assign rd_idx = (LATENCY == 1) ? req_idx : idx_q;

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_data (req_wdata),
        .wr_mask (req_wmask),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= req_idx;
                        wen_q   <= req_wen;
                        err_q   <= !in_range;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = (state_q == RESP && !wen_q && !err_q) ? rd_data : '0;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [63:0] req_addr, req_wdata, rsp_rdata;
    logic [7:0]  req_wmask;
    logic        b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [7:0]  b_req_wmask;

    int   checks = 0;
    int   fails  = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [63:0] m0 [256];
    logic [63:0] m1 [16];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_wen(b_req_wen), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    function automatic exp_t model_op(input bit which, input logic [63:0] a, input logic w,
                                      input logic [63:0] d, input logic [7:0] m);
        exp_t        e;
        int          depth;
        int          idx;
        logic        inr;
        logic [63:0] cur;
        depth = which ? 16 : 256;
        inr   = (a >= BASE) && ((a - BASE) < 64'(depth) * 8);
        idx   = inr ? int'((a - BASE) >> 3) : 0;
        cur   = which ? m1[idx] : m0[idx];
        if (inr && w) begin
            for (int i = 0; i < 8; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
            if (which) m1[idx] = cur; else m0[idx] = cur;
        end
        e.rdata = (inr && !w) ? cur : 64'h0;
        e.err   = !inr;
        return e;
    endfunction

    task automatic send(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
        int k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout addr=%h req_ready stayed %b, required 1", a, req_ready);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            q0.push_back(model_op(1'b0, a, w, d, m));
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic finish_rsp(input string nm);
        int   lat = 1;
        exp_t e;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL %s_latency got %0d edges, required 2", nm, lat);
        end
        if (!rsp_valid || q0.size() == 0) begin
            checks++; fails++;
            $display("FAIL %s_no_response rsp_valid=%b queued=%0d, required a response", nm, rsp_valid, q0.size());
            return;
        end
        e = q0.pop_front();
        checks++;
        if (rsp_rdata !== e.rdata) begin
            fails++;
            $display("FAIL %s_rdata got %h, required %h", nm, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
            fails++;
            $display("FAIL %s_err got %b, required %b", nm, rsp_err, e.err);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_handshake rsp_valid=%b req_ready=%b, required 0/1", nm, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; req_addr = '0; req_wen = 1'b0;
        req_wdata = '0; req_wmask = '0;
        b_req_valid = 1'b0; b_rsp_ready = 1'b1; b_req_addr = '0; b_req_wen = 1'b0;
        b_req_wdata = '0; b_req_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b, required 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_store_load();
        send(BASE + 64'h10, 1'b1, 64'h1122334455667788, 8'hFF);
        finish_rsp("full_store");
        send(BASE + 64'h10, 1'b0, 64'h0, 8'h00);
        finish_rsp("full_load");
    endtask

    task automatic test_partial();
        send(BASE + 64'h10, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
        finish_rsp("partial_store");
        send(BASE + 64'h10, 1'b0, 64'h0, 8'h00);
        finish_rsp("partial_load");
        send(BASE + 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        finish_rsp("zero_mask_store");
        send(BASE + 64'h14, 1'b0, 64'h0, 8'h00);
        finish_rsp("zero_mask_load");
    endtask

    task automatic test_range();
        send(BASE, 1'b1, 64'h0BAD_F00D_CAFE_0001, 8'hFF);
        finish_rsp("base_store");
        send(64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00);
        finish_rsp("below_base");
        send(BASE + 64'd256 * 8, 1'b0, 64'h0, 8'h00);
        finish_rsp("past_end_load");
        send(BASE + 64'd256 * 8, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
        finish_rsp("past_end_store");
        send(BASE, 1'b0, 64'h0, 8'h00);
        finish_rsp("base_after_oob");
        send(BASE + 64'h7F8, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0);
        finish_rsp("top_store");
        send(BASE + 64'h10, 1'b0, 64'h0, 8'h00);
        finish_rsp("inrange_after_err");
    endtask

    task automatic test_backpressure();
        logic [63:0] hold_d;
        logic        hold_e;
        int          k = 0;
        exp_t        e;
        @(negedge clk) rsp_ready = 1'b0;
        send(BASE, 1'b0, 64'h0, 8'h00);
        while (!rsp_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        hold_d = rsp_rdata;
        hold_e = rsp_err;
        if (q0.size() > 0) e = q0.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            fails++;
            $display("FAIL stall_value valid=%b rdata=%h err=%b, required 1/%h/%b",
                     rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== hold_d || rsp_err !== hold_e || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold cycle %0d valid=%b rdata=%h err=%b ready=%b, required 1/%h/%b/0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, hold_d, hold_e);
            end
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_midwait();
        send(BASE + 64'h20, 1'b1, 64'hFEED_FACE_1234_5678, 8'hFF);
        finish_rsp("pre_reset_store");
        send(BASE + 64'h20, 1'b0, 64'h0, 8'h00);
        rst = 1'b1;
        if (q0.size() > 0) void'(q0.pop_front());
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_midwait_outputs valid=%b rdata=%h err=%b ready=%b, required 0/0/0/1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_dropped cycle %0d valid=%b ready=%b, required 0/1", c, rsp_valid, req_ready);
            end
        end
        send(BASE + 64'h20, 1'b0, 64'h0, 8'h00);
        finish_rsp("post_reset_load");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a [8];
        logic        w [8];
        logic [63:0] d [8];
        int          idx = 0;
        int          last = -1;
        int          cyc = 0;
        logic        acc;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            a[i] = BASE + 64'(i * 8);  w[i] = 1'b1; d[i] = {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
            a[i+4] = BASE + 64'((3 - i) * 8); w[i+4] = 1'b0; d[i+4] = 64'h0;
        end
        while (idx < 8 && cyc < 60) begin
            @(negedge clk);
            b_req_valid = 1'b1; b_req_addr = a[idx]; b_req_wen = w[idx];
            b_req_wdata = d[idx]; b_req_wmask = 8'hFF;
            @(posedge clk);
            acc = b_req_valid && b_req_ready;
            if (acc) begin
                q1.push_back(model_op(1'b1, a[idx], w[idx], d[idx], 8'hFF));
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 2) begin
                        fails++;
                        $display("FAIL b2b_spacing op %0d got %0d cycles, required 2", idx, cyc - last);
                    end
                end
                last = cyc;
                idx++;
            end
            #1;
            if (acc) begin
                checks++;
                if (b_rsp_valid !== 1'b1 || q1.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_latency op %0d rsp_valid=%b, required 1 one edge after accept", idx - 1, b_rsp_valid);
                end else begin
                    e = q1.pop_front();
                    checks++;
                    if (b_rsp_rdata !== e.rdata || b_rsp_err !== e.err) begin
                        fails++;
                        $display("FAIL b2b_data op %0d got %h/%b, required %h/%b",
                                 idx - 1, b_rsp_rdata, b_rsp_err, e.rdata, e.err);
                    end
                end
            end
            cyc++;
        end
        @(negedge clk) b_req_valid = 1'b0;
        checks++;
        if (idx != 8) begin
            fails++;
            $display("FAIL b2b_timeout accepted %0d ops, required 8", idx);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m0[i] = 64'h0;
        for (int i = 0; i < 16; i++)  m1[i] = 64'h0;
        test_reset();
        test_store_load();
        test_partial();
        test_range();
        test_backpressure();
        test_reset_midwait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
